// File: rtl/product_accumulator.sv
// Accumulates a programmed number of 8-bit unsigned products and presents the total on a valid/ready output.
// Optional macro SATURATE_EN: clamp the accumulator at 2^ACC_W-1 on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [ACC_W:0]   sum_wide;

  // One spare bit catches the carry out of the accumulator's MSB.
  assign sum_wide = {1'b0, acc_reg} + {{(ACC_W-7){1'b0}}, in_product};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next       = '0;
          ovf_next       = 1'b0;
          remaining_next = len;
          state_next     = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          ovf_next       = ovf_reg | sum_wide[ACC_W];
`ifdef SATURATE_EN
          // Once clamped at all-ones any further carry re-clamps, so the value sticks.
          acc_next       = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
          acc_next       = sum_wide[ACC_W-1:0];
`endif
          remaining_next = remaining_reg - CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from registers: no input-to-output combinational path.
  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_sum   = acc_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two widths (16 and 9 bits) share one directed stimulus stream.
// A job-level model (true total, then wrap or clamp) is compared every cycle, plus literal expectations.
module tb_product_accumulator;
  localparam int CNT_W = 4;
  localparam int WA    = 16;
  localparam int WB    = 9;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, out_ready;
  logic [CNT_W-1:0] len;
  logic [7:0]       in_product;
  logic             a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [WA-1:0]    a_out_sum;
  logic             b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [WB-1:0]    b_out_sum;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(WA), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_product(in_product),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .busy(a_busy)
  );

  product_accumulator #(.ACC_W(WB), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_product(in_product),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .busy(b_busy)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc_cnt = 0;
  bit     chk_en = 1'b0;

  // Model: phase 0 idle, 1 collecting, 2 result pending; total is the exact unbounded sum.
  int     mdl_phase = 0;
  int     mdl_left  = 0;
  longint mdl_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint lim_of(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint exp_sum(input int w);
`ifdef SATURATE_EN
    return (mdl_total > lim_of(w)) ? lim_of(w) : mdl_total;
`else
    return mdl_total & lim_of(w);
`endif
  endfunction

  function automatic longint exp_ovf(input int w);
    return (mdl_total > lim_of(w)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst) begin
      mdl_phase = 0;
      mdl_left  = 0;
      mdl_total = 0;
    end else begin
      case (mdl_phase)
        0: if (start) begin
          mdl_total = 0;
          mdl_left  = int'(len);
          mdl_phase = (len == 0) ? 2 : 1;
        end
        1: if (in_valid) begin
          mdl_total = mdl_total + longint'(in_product);
          mdl_left  = mdl_left - 1;
          if (mdl_left == 0) mdl_phase = 2;
        end
        default: if (out_ready) mdl_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_busy",      64'(a_busy),      64'(mdl_phase != 0));
      check("a_in_ready",  64'(a_in_ready),  64'(mdl_phase == 1));
      check("a_out_valid", 64'(a_out_valid), 64'(mdl_phase == 2));
      check("b_busy",      64'(b_busy),      64'(mdl_phase != 0));
      check("b_in_ready",  64'(b_in_ready),  64'(mdl_phase == 1));
      check("b_out_valid", 64'(b_out_valid), 64'(mdl_phase == 2));
      if (mdl_phase == 2) begin
        check("a_out_sum", 64'(a_out_sum), 64'(exp_sum(WA)));
        check("a_out_ovf", 64'(a_out_ovf), 64'(exp_ovf(WA)));
        check("b_out_sum", 64'(b_out_sum), 64'(exp_sum(WB)));
        check("b_out_ovf", 64'(b_out_ovf), 64'(exp_ovf(WB)));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (a_out_valid && b_out_valid) break;
      cyc();
    end
    check({tag, "_done_in_time"}, 64'(a_out_valid & b_out_valid), 64'd1);
  endtask

  task automatic check_result(input string tag, input longint sa, input bit oa,
                              input longint sb, input bit ob);
    check({tag, "_a_sum"}, 64'(a_out_sum), 64'(sa));
    check({tag, "_a_ovf"}, 64'(a_out_ovf), 64'(oa));
    check({tag, "_b_sum"}, 64'(b_out_sum), 64'(sb));
    check({tag, "_b_ovf"}, 64'(b_out_ovf), 64'(ob));
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check({tag, "_idle_after_pop"}, 64'(a_busy | b_busy | a_out_valid | b_out_valid), 64'd0);
  endtask

  initial begin
    longint start_cyc;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_a_sum",  64'(a_out_sum), 64'd0);
    check("reset_b_sum",  64'(b_out_sum), 64'd0);
    check("reset_ovf",    64'(a_out_ovf | b_out_ovf), 64'd0);
    check("reset_flags",  64'({a_busy, a_in_ready, a_out_valid, b_busy, b_in_ready, b_out_valid}), 64'd0);

    // Basic job: 15 + 225 + 6 with in_valid held high.
    start_cyc = cyc_cnt;
    start = 1'b1; len = 4'd3; in_valid = 1'b1; in_product = 8'd15; cyc();
    start = 1'b0; cyc();
    in_product = 8'd225; cyc();
    in_product = 8'd6; cyc();
    in_valid = 1'b0;
    wait_done("basic");
    check("basic_latency", 64'(cyc_cnt - start_cyc), 64'd4);
    check_result("basic", 246, 1'b0, 246, 1'b0);
    pop("basic");
    $display("job basic: sum_a=%0d sum_b=%0d", a_out_sum, b_out_sum);

    // Gaps in in_valid, then consumer back-pressure.
    start = 1'b1; len = 4'd2; cyc();
    start = 1'b0; in_valid = 1'b1; in_product = 8'd10; cyc();
    in_valid = 1'b0; cyc(); cyc();
    in_valid = 1'b1; in_product = 8'd20; cyc();
    in_valid = 1'b0;
    wait_done("gaps");
    for (int i = 0; i < 5; i++) begin
      check("gaps_hold_sum", 64'(a_out_sum), 64'd30);
      cyc();
    end
    check_result("gaps", 30, 1'b0, 30, 1'b0);
    pop("gaps");
    $display("job gaps: sum_a=%0d", a_out_sum);

    // Zero-length job.
    start = 1'b1; len = 4'd0; cyc();
    start = 1'b0;
    check("len0_valid", 64'(a_out_valid & b_out_valid), 64'd1);
    check("len0_in_ready", 64'(a_in_ready | b_in_ready), 64'd0);
    check_result("len0", 0, 1'b0, 0, 1'b0);
    pop("len0");
    $display("job len0: sum_a=%0d", a_out_sum);

    // Overflow in the 9-bit instance: 255 * 3 = 765.
    start = 1'b1; len = 4'd3; in_valid = 1'b1; in_product = 8'd255; cyc();
    start = 1'b0; cyc(); cyc(); cyc();
    in_valid = 1'b0;
    wait_done("ovf");
`ifdef SATURATE_EN
    check_result("ovf", 765, 1'b0, 511, 1'b1);
`else
    check_result("ovf", 765, 1'b0, 253, 1'b1);
`endif
    pop("ovf");
    $display("job ovf: sum_a=%0d sum_b=%0d ovf_b=%0d", a_out_sum, b_out_sum, b_out_ovf);

    // Reset mid-job after two beats, then a fresh single-term job.
    start = 1'b1; len = 4'd4; in_valid = 1'b0; cyc();
    start = 1'b0; in_valid = 1'b1; in_product = 8'd100; cyc();
    in_product = 8'd50; cyc();
    in_valid = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0;
    check("midrst_busy", 64'(a_busy | b_busy), 64'd0);
    check("midrst_in_ready", 64'(a_in_ready | b_in_ready), 64'd0);
    check("midrst_sum", 64'({a_out_sum, b_out_sum}), 64'd0);
    start = 1'b1; len = 4'd1; cyc();
    start = 1'b0; in_valid = 1'b1; in_product = 8'd7; cyc();
    in_valid = 1'b0;
    wait_done("after_rst");
    check_result("after_rst", 7, 1'b0, 7, 1'b0);
    pop("after_rst");
    $display("job after_rst: sum_a=%0d", a_out_sum);

    // Starts during ACCUM, DONE and the pop cycle must all be ignored.
    start = 1'b1; len = 4'd3; in_valid = 1'b1; in_product = 8'd1; cyc();
    start = 1'b0; cyc();
    start = 1'b1; len = 4'd5; in_product = 8'd2; cyc();
    start = 1'b0; in_product = 8'd3; cyc();
    in_valid = 1'b0;
    check("ign_done_after_3", 64'(a_out_valid & b_out_valid), 64'd1);
    check_result("ign", 6, 1'b0, 6, 1'b0);
    start = 1'b1; len = 4'd2; cyc();
    start = 1'b0;
    check_result("ign_in_done", 6, 1'b0, 6, 1'b0);
    start = 1'b1; out_ready = 1'b1; cyc();
    start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ign_no_second_job", 64'(a_busy | b_busy), 64'd0);
      cyc();
    end
    $display("job ignored_start: sum_a=%0d", a_out_sum);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
